// File: rtl/pulse_stretcher_pkg.sv
// Shared types and elaboration helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timer must hold max(ON,GAP)-1; never narrower than one bit.
  function automatic int timer_width(input int on_cycles, input int gap_cycles);
    int m;
    m = max_int(on_cycles, gap_cycles);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/stretch_timer.sv
// Loadable down-counter that parks at zero and flags when it gets there.
module stretch_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over counting; the count stops at zero instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register, cleared by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Turns one-cycle event strobes into ON/GAP LED flashes, queueing events that
// arrive while a flash is running and replaying them back-to-back.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter  int ON_CYCLES  = 10_000_000,
  parameter  int GAP_CYCLES = 5_000_000,
  parameter  int QUEUE_MAX  = 15,
  localparam int PW         = $clog2(QUEUE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  output logic          led_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int            TW       = timer_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(QUEUE_MAX);

  state_e        state_q;
  state_e        state_d;
  logic          led_q;
  logic          led_d;
  logic          busy_q;
  logic          busy_d;
  logic [PW-1:0] pending_q;
  logic [PW-1:0] pending_d;
  logic          overflow_q;
  logic          overflow_d;

  logic          timer_load;
  logic [TW-1:0] timer_load_value;
  logic          timer_zero;
  logic          start_direct;
  logic          dequeue;
  logic          queue_event;

  stretch_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_load_value),
    .zero       (timer_zero)
  );

  // Next-state: a flash starts either from the queue or by consuming the
  // incoming strobe directly; the timer is reloaded on every phase change.
  always_comb begin
    state_d          = state_q;
    timer_load       = 1'b0;
    timer_load_value = ON_LOAD;
    start_direct     = 1'b0;
    dequeue          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d      = ON;
          timer_load   = 1'b1;
          start_direct = 1'b1;
        end
      end
      ON: begin
        if (timer_zero) begin
          state_d          = GAP;
          timer_load       = 1'b1;
          timer_load_value = GAP_LOAD;
        end
      end
      GAP: begin
        if (timer_zero) begin
          if (pending_q != '0) begin
            state_d    = ON;
            timer_load = 1'b1;
            dequeue    = 1'b1;
          end else if (pulse_in) begin
            state_d      = ON;
            timer_load   = 1'b1;
            start_direct = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating event queue: a simultaneous enqueue and dequeue cancel out,
  // so a full queue only overflows when nothing is leaving it.
  always_comb begin
    queue_event = pulse_in && !start_direct;
    pending_d   = pending_q;
    overflow_d  = 1'b0;
    if (queue_event && dequeue) begin
      pending_d = pending_q;
    end else if (queue_event) begin
      if (pending_q < PEND_MAX) begin
        pending_d = pending_q + PW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else if (dequeue) begin
      pending_d = pending_q - PW'(1);
    end
  end

  // Outputs follow the next state so they line up with the state register.
  always_comb begin
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any flash and drops the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: a flash-slot model runs alongside
// the DUT, plus directed scenarios with hand-computed expectations.
module tb_pulse_stretcher;

  localparam int ON_C  = 4;
  localparam int GAP_C = 2;
  localparam int QMAX  = 3;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse_in = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int flashes = 0;
  int ovf_count = 0;
  bit mon_en = 1'b0;
  logic led_prev = 1'b0;

  pulse_stretcher #(
    .ON_CYCLES  (ON_C),
    .GAP_CYCLES (GAP_C),
    .QUEUE_MAX  (QMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Model: while active, pos is the cycle index inside an ON+GAP flash slot.
  typedef struct {
    bit active;
    int pos;
    int pend;
    bit ovf;
  } model_t;

  model_t m = '{0, 0, 0, 0};

  function automatic model_t model_step(model_t cur, bit p);
    model_t n;
    bit last;
    bit from_q;
    bit direct;
    n = cur;
    n.ovf = 1'b0;
    if (!cur.active) begin
      if (p) begin
        n.active = 1'b1;
        n.pos = 0;
      end
    end else begin
      last   = (cur.pos == ON_C + GAP_C - 1);
      from_q = last && (cur.pend > 0);
      direct = last && (cur.pend == 0) && p;
      if (last) begin
        if (from_q || direct) n.pos = 0;
        else n.active = 1'b0;
      end else begin
        n.pos = cur.pos + 1;
      end
      if (p && !direct) begin
        if (!from_q) begin
          if (cur.pend < QMAX) n.pend = cur.pend + 1;
          else n.ovf = 1'b1;
        end
      end else if (from_q) begin
        n.pend = cur.pend - 1;
      end
    end
    return n;
  endfunction

  // Advance the model on each clock edge; reset empties it.
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{0, 0, 0, 0};
    else m <= model_step(m, pulse_in);
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check_output("model_led", led_out, (m.active && m.pos < ON_C) ? 1 : 0);
      check_output("model_busy", busy, m.active ? 1 : 0);
      check_output("model_pending", pending, m.pend);
      check_output("model_overflow", overflow, m.ovf ? 1 : 0);
      if (led_out && !led_prev) flashes++;
      led_prev = led_out;
      if (overflow) ovf_count++;
    end
  end

  // Drive pulse_in so it is sampled on the edge after the next one.
  task automatic apply_stimulus(input bit p);
    @(posedge clk);
    #1 pulse_in = p;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("wait_idle_timeout", busy, 0);
  endtask

  task automatic run_single(input string tag);
    logic led_exp[7]  = '{1, 1, 1, 1, 0, 0, 0};
    logic busy_exp[7] = '{1, 1, 1, 1, 1, 1, 0};
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_output($sformatf("%s_led_%0d", tag, i), led_out, led_exp[i]);
      check_output($sformatf("%s_busy_%0d", tag, i), busy, busy_exp[i]);
      check_output($sformatf("%s_pending_%0d", tag, i), pending, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f0;
    int o0;
    int rate;
    bit p;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_led", led_out, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_pending", pending, 0);
    check_output("reset_overflow", overflow, 0);
    #2 rst = 1'b1;
    mon_en = 1'b1;

    // Single pulse: 4 cycles on, 2 gap, then idle.
    run_single("s1");
    wait_idle();

    // Three back-to-back pulses queue two events.
    f0 = flashes; o0 = ovf_count;
    apply_stimulus(1'b1); apply_stimulus(1'b1); apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    @(negedge clk);
    check_output("s2_pending_peak", pending, 2);
    wait_idle();
    check_output("s2_flashes", flashes - f0, 3);
    check_output("s2_overflows", ovf_count - o0, 0);

    // Five pulses saturate the queue; the fifth is dropped.
    f0 = flashes; o0 = ovf_count;
    repeat (5) apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    wait_idle();
    check_output("s3_flashes", flashes - f0, 4);
    check_output("s3_overflows", ovf_count - o0, 1);

    // Pulse on the last gap cycle restarts with no idle cycle.
    f0 = flashes;
    apply_stimulus(1'b1);
    repeat (5) apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    @(negedge clk);
    check_output("s4_led", led_out, 1);
    check_output("s4_busy", busy, 1);
    check_output("s4_pending", pending, 0);
    wait_idle();
    check_output("s4_flashes", flashes - f0, 2);

    // Enqueue and dequeue together on a full queue: no overflow.
    f0 = flashes; o0 = ovf_count;
    repeat (5) apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    @(negedge clk);
    check_output("s5_pending", pending, 3);
    check_output("s5_overflow", overflow, 0);
    check_output("s5_led", led_out, 1);
    wait_idle();
    check_output("s5_flashes", flashes - f0, 5);
    check_output("s5_overflows", ovf_count - o0, 1);

    // Reset mid-flash clears everything before the next edge.
    apply_stimulus(1'b1); apply_stimulus(1'b1); apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    #1 check_output("s6_pending_before", pending, 2);
    #1 rst = 1'b0;
    #1;
    check_output("s6_led", led_out, 0);
    check_output("s6_busy", busy, 0);
    check_output("s6_pending", pending, 0);
    check_output("s6_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    run_single("s6b");
    wait_idle();

    // Randomized traffic at several densities, with occasional resets.
    for (int seg = 0; seg < 6; seg++) begin
      case (seg % 3)
        0: rate = 10;
        1: rate = 35;
        default: rate = 75;
      endcase
      for (int c = 0; c < 250; c++) begin
        p = ($urandom_range(0, 99) < rate);
        apply_stimulus(p);
        if ($urandom_range(0, 199) == 0) begin
          #3 rst = 1'b0;
          @(negedge clk);
          #2 rst = 1'b1;
        end
      end
    end
    apply_stimulus(1'b0);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
